// File: rtl/pg_switch_pkg.sv
// Shared types and constants for the power-switch acknowledge model.
package pg_switch_pkg;

    typedef enum logic [1:0] {
        S_ON       = 2'd0,
        S_RAMP_OFF = 2'd1,
        S_OFF      = 2'd2,
        S_RAMP_ON  = 2'd3
    } pg_state_e;

    localparam int unsigned ABORT_CNT_W = 16;

endpackage

// File: rtl/pg_switch_bank_fsm.sv
// One bank's power-switch ramp FSM: ramp counter, registered active-low ack and ramp flag.
module pg_switch_bank_fsm
    import pg_switch_pkg::*;
#(
    parameter int unsigned ON_LATENCY  = 45,
    parameter int unsigned OFF_LATENCY = 45,
    parameter int unsigned CNT_W       = 6
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic switch_n,
    output logic ack_n,
    output logic ramping,
    output logic abort_pulse
);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_LATENCY - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_LATENCY - 1);

    pg_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_n_q, ramping_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        abort_pulse = 1'b0;
        unique case (state_q)
            S_ON: begin
                if (switch_n) begin
                    state_d = S_RAMP_OFF;
                    cnt_d   = OFF_LOAD;
                end
            end
            S_RAMP_OFF: begin
                if (!switch_n) begin
                    state_d     = S_ON;
                    abort_pulse = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_OFF;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_OFF: begin
                if (!switch_n) begin
                    state_d = S_RAMP_ON;
                    cnt_d   = ON_LOAD;
                end
            end
            S_RAMP_ON: begin
                if (switch_n) begin
                    state_d     = S_OFF;
                    abort_pulse = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_ON;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_ON;
        endcase
    end

    // Ack and ramp flag are registered from the next state so they change on the
    // same edge as the state, without decode glitches.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_ON;
            cnt_q     <= '0;
            ack_n_q   <= 1'b0;
            ramping_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ack_n_q   <= (state_d == S_OFF) || (state_d == S_RAMP_ON);
            ramping_q <= (state_d == S_RAMP_OFF) || (state_d == S_RAMP_ON);
        end
    end

    assign ack_n   = ack_n_q;
    assign ramping = ramping_q;

endmodule

// File: rtl/pg_switch_ack_model.sv
// Per-bank power-switch acknowledge model with programmable ramp latencies,
// ramp abort handling, a busy flag and a saturating abort counter.
module pg_switch_ack_model
    import pg_switch_pkg::*;
#(
    parameter int unsigned NUM_BANKS   = 2,
    parameter int unsigned ON_LATENCY  = 45,
    parameter int unsigned OFF_LATENCY = 45
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_BANKS-1:0]   switch_n_i,
    output logic [NUM_BANKS-1:0]   ack_n_o,
    output logic                   busy_o,
    output logic [ABORT_CNT_W-1:0] abort_cnt_o
);

    localparam int unsigned MAX_LATENCY = (ON_LATENCY > OFF_LATENCY) ? ON_LATENCY : OFF_LATENCY;
    localparam int unsigned CNT_W       = $clog2(MAX_LATENCY + 1);
    localparam int unsigned SUM_W       = ABORT_CNT_W + $clog2(NUM_BANKS + 1);

    if (ON_LATENCY < 1) begin : g_chk_on
        $fatal(1, "pg_switch_ack_model: ON_LATENCY must be >= 1");
    end
    if (OFF_LATENCY < 1) begin : g_chk_off
        $fatal(1, "pg_switch_ack_model: OFF_LATENCY must be >= 1");
    end
    if (NUM_BANKS < 1) begin : g_chk_banks
        $fatal(1, "pg_switch_ack_model: NUM_BANKS must be >= 1");
    end

    logic [NUM_BANKS-1:0]   ramping;
    logic [NUM_BANKS-1:0]   abort_pulse;
    logic [ABORT_CNT_W-1:0] abort_cnt_q, abort_cnt_d;
    logic [SUM_W-1:0]       abort_sum;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        pg_switch_bank_fsm #(
            .ON_LATENCY  (ON_LATENCY),
            .OFF_LATENCY (OFF_LATENCY),
            .CNT_W       (CNT_W)
        ) u_bank (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .switch_n    (switch_n_i[g]),
            .ack_n       (ack_n_o[g]),
            .ramping     (ramping[g]),
            .abort_pulse (abort_pulse[g])
        );
    end

    always_comb begin
        abort_sum = SUM_W'(abort_cnt_q);
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            abort_sum = abort_sum + SUM_W'(abort_pulse[i]);
        end
        if (abort_sum > SUM_W'({ABORT_CNT_W{1'b1}})) begin
            abort_cnt_d = '1;
        end else begin
            abort_cnt_d = abort_sum[ABORT_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            abort_cnt_q <= '0;
        end else begin
            abort_cnt_q <= abort_cnt_d;
        end
    end

    // Each bank's ramp flag is already a register, so the OR stays glitch-free.
    assign busy_o      = |ramping;
    assign abort_cnt_o = abort_cnt_q;

endmodule

// File: tb/tb_pg_switch_ack_model.sv
// Directed self-checking bench for pg_switch_ack_model (4 banks, on=45, off=10).
module tb_pg_switch_ack_model;

    localparam int unsigned NB  = 4;
    localparam int unsigned ON  = 45;
    localparam int unsigned OFF = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] switch_n;
    logic [NB-1:0] ack_n;
    logic          busy;
    logic [15:0]   abort_cnt;

    int errors = 0;
    int checks = 0;

    pg_switch_ack_model #(
        .NUM_BANKS   (NB),
        .ON_LATENCY  (ON),
        .OFF_LATENCY (OFF)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .switch_n_i  (switch_n),
        .ack_n_o     (ack_n),
        .busy_o      (busy),
        .abort_cnt_o (abort_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_state(input string name, input logic [NB-1:0] exp_ack,
                             input logic exp_busy, input logic [15:0] exp_cnt);
        checks++;
        if (ack_n !== exp_ack) begin
            errors++;
            $display("FAIL %s ack_n: got %b want %b", name, ack_n, exp_ack);
        end
        checks++;
        if (busy !== exp_busy) begin
            errors++;
            $display("FAIL %s busy: got %b want %b", name, busy, exp_busy);
        end
        checks++;
        if (abort_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s abort_cnt: got %h want %h", name, abort_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        switch_n = 4'b0000;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk_state("reset", 4'b0000, 1'b0, 16'h0000);
    endtask

    task automatic test_off_on();
        switch_n[1] = 1'b1;
        for (int i = 0; i < int'(OFF); i++) begin
            tick(1);
            chk_state("off_ramp", 4'b0000, 1'b1, 16'h0000);
        end
        tick(1);
        chk_state("off_done", 4'b0010, 1'b0, 16'h0000);
        switch_n[1] = 1'b0;
        for (int i = 0; i < int'(ON); i++) begin
            tick(1);
            chk_state("on_ramp", 4'b0010, 1'b1, 16'h0000);
        end
        tick(1);
        chk_state("on_done", 4'b0000, 1'b0, 16'h0000);
    endtask

    task automatic test_abort();
        switch_n[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk_state("abort_pre", 4'b0000, 1'b1, 16'h0000);
        end
        switch_n[2] = 1'b0;
        tick(1);
        chk_state("abort_edge", 4'b0000, 1'b0, 16'h0001);
        // Re-request must restart the full ramp.
        switch_n[2] = 1'b1;
        for (int i = 0; i < int'(OFF); i++) begin
            tick(1);
            chk_state("rereq_ramp", 4'b0000, 1'b1, 16'h0001);
        end
        tick(1);
        chk_state("rereq_done", 4'b0100, 1'b0, 16'h0001);
        switch_n[2] = 1'b0;
        tick(ON + 1);
        chk_state("abort_restore", 4'b0000, 1'b0, 16'h0001);
    endtask

    task automatic test_simul_abort();
        switch_n = 4'b1011;
        tick(OFF + 1);
        chk_state("simul_off", 4'b1011, 1'b0, 16'h0001);
        switch_n = 4'b0000;
        tick(3);
        chk_state("simul_ramp", 4'b1011, 1'b1, 16'h0001);
        switch_n = 4'b1011;
        tick(1);
        chk_state("simul_abort", 4'b1011, 1'b0, 16'h0004);

        force dut.abort_cnt_q = 16'hFFFE;
        tick(2);
        release dut.abort_cnt_q;
        tick(1);
        chk_state("preload", 4'b1011, 1'b0, 16'hFFFE);
        switch_n = 4'b0000;
        tick(3);
        switch_n = 4'b1011;
        tick(1);
        chk_state("saturate", 4'b1011, 1'b0, 16'hFFFF);
        switch_n = 4'b0000;
        tick(2);
        switch_n = 4'b1011;
        tick(1);
        chk_state("saturate_hold", 4'b1011, 1'b0, 16'hFFFF);

        switch_n = 4'b0000;
        tick(ON + 1);
        chk_state("simul_restore", 4'b0000, 1'b0, 16'hFFFF);
    endtask

    task automatic test_reset_mid_ramp();
        switch_n = 4'b0001;
        tick(OFF + 1);
        chk_state("mid_off", 4'b0001, 1'b0, 16'hFFFF);
        switch_n = 4'b0000;
        tick(20);
        chk_state("mid_ramp", 4'b0001, 1'b1, 16'hFFFF);
        rst_n = 1'b0;
        tick(1);
        chk_state("mid_reset", 4'b0000, 1'b0, 16'h0000);
        rst_n = 1'b1;
        tick(2);
        chk_state("mid_after", 4'b0000, 1'b0, 16'h0000);
    endtask

    // Scoreboard: bank b is requested at cycle 3*b and must toggle lat cycles later.
    task automatic stagger(input logic to_off, input int lat, input string name);
        logic [NB-1:0] exp_ack;
        logic          exp_busy;
        int            req;
        for (int t = 0; t < 3 * int'(NB) + lat + 3; t++) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (t == 3 * b) switch_n[b] = to_off;
            end
            tick(1);
            exp_busy = 1'b0;
            for (int b = 0; b < int'(NB); b++) begin
                req        = 3 * b;
                exp_ack[b] = (t >= req + lat) ? to_off : ~to_off;
                if (t >= req && t < req + lat) exp_busy = 1'b1;
            end
            chk_state(name, exp_ack, exp_busy, 16'h0000);
        end
    endtask

    task automatic test_independence();
        stagger(1'b1, int'(OFF), "indep_off");
        stagger(1'b0, int'(ON), "indep_on");
    endtask

    initial begin
        rst_n    = 1'b0;
        switch_n = '0;
        test_reset();
        test_off_on();
        test_abort();
        test_simul_abort();
        test_reset_mid_ramp();
        test_independence();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
